// File: rtl/sram_responder_if.sv
// Request/response bundle between the pipeline's instruction and data SRAM
// ports and the on-chip memory responder.
interface sram_responder_if;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        inst_addr_err;
  logic        data_addr_err;
  logic        ready;

  modport master (
    output inst_sram_en, inst_sram_addr,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  inst_sram_rdata, data_sram_rdata, inst_addr_err, data_addr_err, ready
  );

  modport slave (
    input  inst_sram_en, inst_sram_addr,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata, inst_addr_err, data_addr_err, ready
  );
endinterface

// File: rtl/sram_responder.sv
// On-chip memory answering a read-only instruction port and a byte-writable
// data port with 1-cycle read latency; zero-fills itself after reset.
module sram_responder #(
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sram_responder_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e                RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [DEPTH_LOG2-1:0] CNT_ONE     = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] CNT_LAST    = DEPTH_LOG2'(DEPTH - 1);

  function automatic logic in_range(input logic [31:0] addr);
    in_range = ((addr >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  wen);
    for (int b = 0; b < 4; b++) begin
      merge_bytes[8*b +: 8] = wen[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
  endfunction

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic [31:0]           mem_q [DEPTH];

  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_err_q, inst_err_d;
  logic        data_err_q, data_err_d;

  logic [DEPTH_LOG2-1:0] inst_idx_s, data_idx_s;
  logic                  inst_ok_s, data_ok_s, data_we_s;
  logic [31:0]           data_merged_s;
  logic                  unused_addr_lsb;

  assign inst_idx_s      = bus.inst_sram_addr[DEPTH_LOG2+1:2];
  assign data_idx_s      = bus.data_sram_addr[DEPTH_LOG2+1:2];
  assign inst_ok_s       = in_range(bus.inst_sram_addr);
  assign data_ok_s       = in_range(bus.data_sram_addr);
  assign data_merged_s   = merge_bytes(mem_q[data_idx_s], bus.data_sram_wdata, bus.data_sram_wen);
  assign unused_addr_lsb = ^{bus.inst_sram_addr[1:0], bus.data_sram_addr[1:0]};

  // State and clear-counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: walk the array once in CLEAR, then stay in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: read data, range errors and the data-port write strobe
  always_comb begin
    inst_rdata_d = 32'd0;
    data_rdata_d = 32'd0;
    inst_err_d   = 1'b0;
    data_err_d   = 1'b0;
    data_we_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.inst_sram_en) begin
          inst_rdata_d = inst_ok_s ? mem_q[inst_idx_s] : 32'd0;
          inst_err_d   = !inst_ok_s;
        end else begin
          inst_rdata_d = inst_rdata_q;
        end
        // Data port is write-first: the returned word already carries the new bytes.
        if (bus.data_sram_en) begin
          data_rdata_d = data_ok_s ? data_merged_s : 32'd0;
          data_err_d   = !data_ok_s;
          data_we_s    = data_ok_s && (bus.data_sram_wen != 4'b0000);
        end else begin
          data_rdata_d = data_rdata_q;
        end
      end
      default: begin
        inst_rdata_d = 32'd0;
        data_rdata_d = 32'd0;
      end
    endcase
  end

  // Registered response outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_err_q   <= 1'b0;
      data_err_q   <= 1'b0;
    end else begin
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_err_q   <= inst_err_d;
      data_err_q   <= data_err_d;
    end
  end

  // Array write port; reset itself leaves the contents alone
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= 32'd0;
      end else if (data_we_s) begin
        mem_q[data_idx_s] <= data_merged_s;
      end
    end
  end

  assign bus.inst_sram_rdata = inst_rdata_q;
  assign bus.data_sram_rdata = data_rdata_q;
  assign bus.inst_addr_err   = inst_err_q;
  assign bus.data_addr_err   = data_err_q;
  assign bus.ready           = (state_q == ST_RUN);

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: clear sequencing, byte writes,
// port collision, out-of-range handling and output hold.
module tb_sram_responder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sram_responder_if bus_c ();
  sram_responder_if bus_n ();

  sram_responder #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_c)
  );

  sram_responder #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_n)
  );

  typedef struct {
    logic        ie;
    logic [31:0] ia;
    logic        de;
    logic [3:0]  wen;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] ei;
    logic [31:0] ed;
    logic        eie;
    logic        ede;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ie, input logic [31:0] ia, input logic de,
                       input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd);
    bus_c.inst_sram_en    = ie;
    bus_c.inst_sram_addr  = ia;
    bus_c.data_sram_en    = de;
    bus_c.data_sram_wen   = wen;
    bus_c.data_sram_addr  = da;
    bus_c.data_sram_wdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic ie, input logic [31:0] ia, input logic de,
                              input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd,
                              input logic [31:0] ei, input logic [31:0] ed,
                              input logic eie, input logic ede);
    vec_t v;
    v.ie = ie; v.ia = ia; v.de = de; v.wen = wen; v.da = da; v.wd = wd;
    v.ei = ei; v.ed = ed; v.eie = eie; v.ede = ede;
    vecs.push_back(v);
  endfunction

  initial begin
    // Vector table: each row's expectations are the outputs after its edge.
    for (int w = 0; w < 16; w++) begin
      add(1'b1, 32'(4 * w), 1'b1, 4'b0000, 32'(4 * w), 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    end
    add(1'b0, 32'h0,    1'b1, 4'b1111, 32'h8,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    add(1'b0, 32'h0,    1'b1, 4'b0010, 32'h8,  32'h0000AA00, 32'h0,        32'hDEADAAEF, 1'b0, 1'b0);
    add(1'b1, 32'h8,    1'b0, 4'b0000, 32'h0,  32'h0,        32'hDEADAAEF, 32'hDEADAAEF, 1'b0, 1'b0);
    add(1'b1, 32'h8,    1'b1, 4'b1111, 32'h8,  32'h11223344, 32'hDEADAAEF, 32'h11223344, 1'b0, 1'b0);
    add(1'b1, 32'h8,    1'b0, 4'b0000, 32'h0,  32'h0,        32'h11223344, 32'h11223344, 1'b0, 1'b0);
    add(1'b0, 32'h0,    1'b1, 4'b1111, 32'h40, 32'hFFFFFFFF, 32'h11223344, 32'h0,        1'b0, 1'b1);
    add(1'b0, 32'h0,    1'b1, 4'b0000, 32'h0,  32'h0,        32'h11223344, 32'h0,        1'b0, 1'b0);
    add(1'b1, 32'h1000, 1'b0, 4'b0000, 32'h0,  32'h0,        32'h0,        32'h0,        1'b1, 1'b0);
    add(1'b0, 32'h0,    1'b0, 4'b0000, 32'h0,  32'h0,        32'h0,        32'h0,        1'b0, 1'b0);
    add(1'b1, 32'h8,    1'b1, 4'b0000, 32'h8,  32'h55555555, 32'h11223344, 32'h11223344, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      add(1'b0, 32'h0,  1'b0, 4'b1111, 32'h8,  32'hBAD0BAD0, 32'h11223344, 32'h11223344, 1'b0, 1'b0);
    end
    add(1'b1, 32'h8,    1'b1, 4'b0000, 32'h8,  32'h0,        32'h11223344, 32'h11223344, 1'b0, 1'b0);
    add(1'b1, 32'h3C,   1'b1, 4'b0001, 32'h4,  32'h000000A5, 32'h0,        32'h000000A5, 1'b0, 1'b0);
    add(1'b1, 32'h4,    1'b0, 4'b0000, 32'h0,  32'h0,        32'h000000A5, 32'h000000A5, 1'b0, 1'b0);
    add(1'b1, 32'h6,    1'b0, 4'b0000, 32'h0,  32'h0,        32'h000000A5, 32'h000000A5, 1'b0, 1'b0);

    bus_n.inst_sram_en    = 1'b0;
    bus_n.inst_sram_addr  = 32'h0;
    bus_n.data_sram_en    = 1'b0;
    bus_n.data_sram_wen   = 4'b0000;
    bus_n.data_sram_addr  = 32'h0;
    bus_n.data_sram_wdata = 32'h0;
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);

    rst = 1'b1;
    repeat (2) step();
    check("reset.irdata", bus_c.inst_sram_rdata, 32'h0);
    check("reset.drdata", bus_c.data_sram_rdata, 32'h0);
    check("reset.ierr",   32'(bus_c.inst_addr_err), 32'h0);
    check("reset.derr",   32'(bus_c.data_addr_err), 32'h0);
    check("reset.ready",  32'(bus_c.ready), 32'h0);
    check("nc.reset.ready", 32'(bus_n.ready), 32'h1);

    // Partial clear, then reset again mid-CLEAR.
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      check($sformatf("clear1.ready[%0d]", e), 32'(bus_c.ready), 32'h0);
    end
    rst = 1'b1;
    step();
    check("restart.ready", 32'(bus_c.ready), 32'h0);
    rst = 1'b0;

    // Full clear with writes/reads attempted along the way.
    for (int e = 1; e <= 16; e++) begin
      if (e >= 2 && e <= 15) drive(1'b1, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hCAFEBABE);
      else                   drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
      step();
      check($sformatf("clear2.ready[%0d]", e), 32'(bus_c.ready), (e == 16) ? 32'h1 : 32'h0);
      if (e == 8) begin
        check("clear.drdata", bus_c.data_sram_rdata, 32'h0);
        check("clear.derr",   32'(bus_c.data_addr_err), 32'h0);
      end
    end
    check("nc.ready", 32'(bus_n.ready), 32'h1);

    foreach (vecs[i]) begin
      drive(vecs[i].ie, vecs[i].ia, vecs[i].de, vecs[i].wen, vecs[i].da, vecs[i].wd);
      step();
      check($sformatf("vec%0d.irdata", i), bus_c.inst_sram_rdata, vecs[i].ei);
      check($sformatf("vec%0d.drdata", i), bus_c.data_sram_rdata, vecs[i].ed);
      check($sformatf("vec%0d.ierr", i),   32'(bus_c.inst_addr_err), 32'(vecs[i].eie));
      check($sformatf("vec%0d.derr", i),   32'(bus_c.data_addr_err), 32'(vecs[i].ede));
    end

    // Ready stays up in RUN.
    drive(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (2) step();
    check("run.ready", 32'(bus_c.ready), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
On-chip memory model answering the pipeline's instruction and data SRAM request ports. The instruction port is read-only and the data port is read/write with byte enables. Read data is returned with 1-cycle latency. After reset an internal sequencer zero-fills the array before the block accepts requests, so simulation and FPGA bring-up start from a known memory image.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2).
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the fill and go straight to RUN.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
inst_sram_en  input  1  instruction read request
inst_sram_addr  input  32  instruction byte address
inst_sram_rdata  output  32  instruction read data, valid the cycle after the request
data_sram_en  input  1  data access request
data_sram_wen  input  4  byte write enables; wen[i] covers wdata[8i+7:8i]
data_sram_addr  input  32  data byte address
data_sram_wdata  input  32  data write word
data_sram_rdata  output  32  data read data, valid the cycle after the request
inst_addr_err  output  1  one-cycle pulse: previous instruction request was out of range
data_addr_err  output  1  one-cycle pulse: previous data request was out of range
ready  output  1  high once the array is initialised and requests are served

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Addressing:
  - Word index = addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored; alignment is checked upstream.
  - A request is out of range when addr[31:DEPTH_LOG2+2] != 0.
- Reset (rst=1 at an edge):
  - inst_sram_rdata, data_sram_rdata, inst_addr_err and data_addr_err all become 0.
  - Clear counter becomes 0.
  - State becomes CLEAR with ready=0 if CLEAR_ON_RESET=1; otherwise state becomes RUN with ready=1.
  - Array contents are not touched by reset itself.
- State machine, two states:
  - CLEAR: each edge writes mem[cnt]=0 and increments cnt. On the edge that clears word DEPTH-1, the state becomes RUN and ready=1. ready therefore rises DEPTH edges after the first edge with rst=0.
  - RUN: terminal until the next rst.
- Reset asserted mid-CLEAR restarts the counter at 0.
- Requests in CLEAR are ignored: no writes, rdata outputs driven 0, err outputs 0.
- Read latency (RUN): when en=1, rdata is registered at the edge and visible the following cycle. When en=0, rdata holds its previous value.
- Data write (RUN, data_sram_en=1, wen!=0, in range):
  - Only the enabled byte lanes are updated.
  - data_sram_rdata the next cycle is the merged new word (write-first).
  - wen=0000 with en=1 is a plain read.
- Port collision: instruction read and data write to the same index in the same cycle.
  - inst_sram_rdata returns the pre-write word (read-first).
  - The write still completes.
- Out-of-range request (RUN, en=1):
  - No array write.
  - The corresponding rdata becomes 0 the next cycle.
  - The corresponding err output is 1 for exactly that cycle.
  - The err outputs are otherwise 0.
- The two ports are independent; both may hit any index every cycle with no stall.

Test Plan:
- DEPTH_LOG2=4, CLEAR_ON_RESET=1: release rst → ready=0 for 16 cycles, then 1. Read words 0..15 on both ports → all 0x00000000.
- Data write 0xDEADBEEF, wen=1111, addr 0x8; next cycle rdata=0xDEADBEEF. Then write wen=0010, wdata=0x0000AA00, addr 0x8 → rdata=0xDEADAAEF. A later inst read of 0x8 → 0xDEADAAEF.
- Collision: in the same cycle, inst read 0x8 and data write 0x11223344 (wen=1111) to 0x8. Next cycle inst_sram_rdata=0xDEADAAEF and data_sram_rdata=0x11223344. The following inst read of 0x8 → 0x11223344.
- Out of range (DEPTH=16): data write 0xFFFFFFFF to 0x40 → next cycle data_addr_err=1 for one cycle and data_sram_rdata=0. A read of 0x0 still returns its prior value. Inst read of 0x1000 → inst_addr_err=1 for one cycle and inst_sram_rdata=0.
- Hold: perform a read returning 0x11223344, then drive en=0 on both ports for 3 cycles → both rdata outputs stay constant. Writes with en=0 → no array change.
- Reset mid-CLEAR: assert rst at clear cycle 5 → ready stays 0 for 16 full cycles after the new release. A data write issued during CLEAR is not stored (read after ready → 0). CLEAR_ON_RESET=0 → ready=1 on the first edge after reset.
